scan_mux_nto1: RTL

- Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready output handshake.
- Two modes:
  - Manual: sample the selected channel on request.
  - Auto-scan: round-robin through all channels, emitting one sample per channel after a programmable dwell.
- Sits between multi-channel data sources (sensor/ADC lanes) and a single downstream consumer that may stall.

---
 rtl/scan_mux_pkg.sv | 18 +
 rtl/mux_nto1.sv | 19 +
 rtl/scan_mux_nto1.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux_nto1 channel sampler.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN_WAIT = 2'd1,
    SCAN_EMIT = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Dwell counter width; a single-cycle dwell still needs one bit.
  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// Purely combinational N_CH x W selector; out-of-range selects yield zero.
module mux_nto1 #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH*W-1:0] din_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [W-1:0]      y_o
);

  always_comb begin
    y_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_i == SEL_W'(k)) y_o = din_i[k*W +: W];
    end
  end

endmodule

// File: rtl/scan_mux_nto1.sv
// N-channel sampler with manual and round-robin scan modes, one-entry registered
// valid/ready output. Optional per-channel enable mask under SCAN_MUX_CH_MASK_EN.
//
// Output handshake: out_data/out_ch are meaningful while out_valid=1 and are
// held stable until a clock edge with out_valid && out_ready, which is the
// transfer. A new capture on the transfer edge replaces the sample in place.
module scan_mux_nto1
  import scan_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int DWELL = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] din,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sample_req,
  input  logic              out_ready,
`ifdef SCAN_MUX_CH_MASK_EN
  input  logic [N_CH-1:0]   ch_mask,
`endif
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              sel_err,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W    = cnt_width(DWELL);
  localparam int EN_PAD_W = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_CH - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [W-1:0]      data_q, data_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic              err_q, err_d;

  logic              load_ok;
  logic              capture;
  logic              sel_bad;
  logic              any_en;
  logic [N_CH-1:0]   en_mask;
  logic [EN_PAD_W-1:0] en_pad;
  logic [SEL_W-1:0]  scan_ch;
  logic [SEL_W-1:0]  scan_nxt;
  logic [SEL_W-1:0]  mux_sel;
  logic [W-1:0]      mux_y;

`ifdef SCAN_MUX_CH_MASK_EN
  assign en_mask = ch_mask;

  // Capture the first enabled channel at or after the pointer, then park the
  // pointer on the first enabled channel after the one captured.
  always_comb begin
    scan_ch  = ptr_q;
    scan_nxt = ptr_q;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_mask[(int'(ptr_q) + i) % N_CH]) scan_ch = SEL_W'((int'(ptr_q) + i) % N_CH);
    end
    for (int i = N_CH; i >= 1; i--) begin
      if (en_mask[(int'(scan_ch) + i) % N_CH]) scan_nxt = SEL_W'((int'(scan_ch) + i) % N_CH);
    end
  end
`else
  assign en_mask  = '1;
  assign scan_ch  = ptr_q;
  assign scan_nxt = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
`endif

  // Zero-padding to the full select range makes out-of-range selects read as disabled.
  assign en_pad  = EN_PAD_W'(en_mask);
  assign sel_bad = !en_pad[sel];
  assign any_en  = |en_mask;
  assign load_ok = !valid_q || out_ready;
  assign mux_sel = (state_q == IDLE) ? sel : scan_ch;

  mux_nto1 #(
    .N_CH  (N_CH),
    .W     (W),
    .SEL_W (SEL_W)
  ) u_mux (
    .din_i (din),
    .sel_i (mux_sel),
    .y_o   (mux_y)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mode == MODE_SCAN) begin
          state_d = SCAN_WAIT;
          cnt_d   = '0;
        end else if (sample_req) begin
          if (sel_bad) err_d = 1'b1;
          else         capture = load_ok;
        end
      end
      SCAN_WAIT: begin
        if (mode == MODE_MANUAL) begin
          state_d = IDLE;
          ptr_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          if (any_en) begin
            state_d = SCAN_EMIT;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SCAN_EMIT: begin
        if (mode == MODE_MANUAL) begin
          state_d = IDLE;
          ptr_d   = '0;
          cnt_d   = '0;
        end else if (!any_en) begin
          // Mask emptied while waiting to emit: fall back and re-arm immediately.
          state_d = SCAN_WAIT;
          cnt_d   = CNT_LAST;
        end else if (load_ok) begin
          capture = 1'b1;
          ptr_d   = scan_nxt;
          cnt_d   = '0;
          state_d = SCAN_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (capture) begin
      valid_d = 1'b1;
      data_d  = mux_y;
      ch_d    = mux_sel;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_ch      = ch_q;
  assign sel_err     = err_q;
  assign dbg_state_o = state_q;

endmodule
